// File: rtl/spart_pkg.sv
// ============================================================================
// Module : spart_pkg
// Shared types and helpers for the SPART processor-side bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spart_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA   = 2'b00,
      ADDR_STATUS = 2'b01,
      ADDR_DIV_LO = 2'b10,
      ADDR_DIV_HI = 2'b11
   } spart_addr_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10,
      LOCKED = 2'b11
   } arb_state_t;

   localparam logic SPART_RD = 1'b1;
   localparam logic SPART_WR = 1'b0;

   // Data-register accesses wait for the SPART side; all other registers never stall.
   function automatic logic data_stall(input logic [1:0] a, input logic r,
                                       input logic tbr, input logic rda);
      return (a == ADDR_DATA) && ((r == SPART_WR && !tbr) || (r == SPART_RD && !rda));
   endfunction

endpackage

`default_nettype wire

// File: rtl/spart_rr_pick.sv
// ============================================================================
// Module : spart_rr_pick
// Combinational round-robin picker: first eligible master at or above ptr, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [PW-1:0]      pick_idx,
   output logic               valid
);

   always_comb begin
      int idx;
      pick     = '0;
      pick_idx = '0;
      valid    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!valid && eligible[PW'(idx)]) begin
            valid              = 1'b1;
            pick[PW'(idx)]     = 1'b1;
            pick_idx           = PW'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spart_bus_arbiter.sv
// ============================================================================
// Module : spart_bus_arbiter
// Round-robin arbiter sharing the SPART I/O bus between NUM_REQ masters, with
// lockable back-to-back ownership. Macro SPART_ARB_LOCK_TIMEOUT_EN adds a
// forced release after LOCK_TIMEOUT idle LOCKED cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_bus_arbiter
   import spart_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     lock,
   input  logic [NUM_REQ-1:0]     rw,
   input  logic [2*NUM_REQ-1:0]   addr,
   input  logic [8*NUM_REQ-1:0]   wdata,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic [7:0]             rdata,
   output logic                   iocs,
   output logic                   iorw,
   output logic [1:0]             ioaddr,
   inout  wire  [7:0]             databus,
   input  logic                   rda,
   input  logic                   tbr
);

   localparam int PW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || LOCK_TIMEOUT < 1) begin : g_param_check
      $error("spart_bus_arbiter: NUM_REQ must be >= 2 and LOCK_TIMEOUT >= 1");
   end

   arb_state_t           r_state, w_nstate;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [PW-1:0]        r_owner, r_ptr;
   logic                 r_rw;
   logic [1:0]           r_addr;
   logic [7:0]           r_wdata, r_rdata;

   logic [NUM_REQ-1:0]   w_elig, w_pick;
   logic [PW-1:0]        w_pick_idx, w_load_idx;
   logic                 w_pick_valid, w_load, w_drive, w_timeout;
   logic                 w_own_lock, w_own_elig;
   logic                 w_sel_rw;
   logic [1:0]           w_sel_addr;
   logic [7:0]           w_sel_wdata;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_REQ; i++)
         w_elig[i] = req[i] && !data_stall(addr[2*i +: 2], rw[i], tbr, rda);
   end

   spart_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
      .eligible (w_elig),
      .ptr      (r_ptr),
      .pick     (w_pick),
      .pick_idx (w_pick_idx),
      .valid    (w_pick_valid)
   );

   always_comb begin
      w_own_lock = 1'b0;
      w_own_elig = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == r_owner) begin
            w_own_lock = lock[i];
            w_own_elig = w_elig[i];
         end
      end
   end

   always_comb begin
      w_sel_rw    = SPART_RD;
      w_sel_addr  = ADDR_STATUS;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == w_load_idx) begin
            w_sel_rw    = rw[i];
            w_sel_addr  = addr[2*i +: 2];
            w_sel_wdata = wdata[8*i +: 8];
         end
      end
   end

`ifdef SPART_ARB_LOCK_TIMEOUT_EN
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   logic [CW-1:0] r_lock_cnt;

   assign w_timeout = (r_lock_cnt == CW'(LOCK_TIMEOUT - 1));

   // Any non-LOCKED state (including an owner ACCESS) restarts the idle count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_lock_cnt <= '0;
      else if (r_state != LOCKED) r_lock_cnt <= '0;
      else if (!w_timeout)        r_lock_cnt <= r_lock_cnt + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_nstate   = r_state;
      w_load     = 1'b0;
      w_load_idx = r_owner;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_nstate   = ACCESS;
               w_load     = 1'b1;
               w_load_idx = w_pick_idx;
            end
         end
         ACCESS: w_nstate = DONE;
         DONE:   w_nstate = w_own_lock ? LOCKED : IDLE;
         LOCKED: begin
            if (!w_own_lock) begin
               w_nstate = IDLE;
            end else if (w_own_elig) begin
               w_nstate = ACCESS;
               w_load   = 1'b1;
            end else if (w_timeout) begin
               w_nstate = IDLE;
            end
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_rw    <= SPART_RD;
         r_addr  <= ADDR_STATUS;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_nstate;
         if (w_load) begin
            r_owner <= w_load_idx;
            r_rw    <= w_sel_rw;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
         end
         if (r_state == IDLE && w_load) begin
            r_gnt <= w_pick;
            r_ptr <= next_idx(w_pick_idx);
         end else if (w_nstate == IDLE) begin
            r_gnt <= '0;
            if (r_state == LOCKED) r_ptr <= next_idx(r_owner);
         end
         if (r_state == ACCESS && r_rw == SPART_RD) r_rdata <= databus;
      end
   end

   always_comb begin
      iocs    = 1'b0;
      iorw    = SPART_RD;
      ioaddr  = ADDR_STATUS;
      done    = '0;
      w_drive = 1'b0;
      case (r_state)
         ACCESS: begin
            iocs    = 1'b1;
            iorw    = r_rw;
            ioaddr  = r_addr;
            w_drive = (r_rw == SPART_WR);
         end
         DONE:    done = r_gnt;
         default: ;
      endcase
   end

   assign databus = w_drive ? r_wdata : 8'hzz;
   assign gnt     = r_gnt;
   assign rdata   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_spart_bus_arbiter.sv
// ============================================================================
// Module : tb_spart_bus_arbiter
// Directed scoreboard bench for spart_bus_arbiter (two masters, SPART bus model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spart_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, lock, rw;
   logic [3:0]  addr;
   logic [15:0] wdata;
   logic        rda, tbr;
   wire  [1:0]  gnt, done;
   wire  [7:0]  rdata;
   wire         iocs, iorw;
   wire  [1:0]  ioaddr;
   wire  [7:0]  databus;

   // SPART model: returns data/status on reads, parks 8'h96 whenever the arbiter must not drive.
   logic       tb_en;
   logic [7:0] tb_val;
   always_comb begin
      tb_en  = !(iocs && !iorw);
      tb_val = 8'h96;
      if (iocs && iorw) tb_val = (ioaddr == 2'b00) ? 8'h5A : 8'hC3;
   end
   assign databus = tb_en ? tb_val : 8'hzz;

   always #5 clk = ~clk;

   spart_bus_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .rw(rw), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus(databus), .rda(rda), .tbr(tbr)
   );

   typedef struct {
      int         m;
      logic       rw;
      logic [1:0] a;
      logic [7:0] d;
   } txn_t;

   txn_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   string      step = "init";
   logic       bus_seen;
   logic [1:0] done_seen, gnt_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh(input int m);
      return (m == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic issue(input int m, input logic r, input logic [1:0] a,
                        input logic [7:0] d, input logic lk);
      rw[m] = r; addr[2*m +: 2] = a; wdata[8*m +: 8] = d; lock[m] = lk; req[m] = 1'b1;
   endtask

   task automatic push_exp(input int m, input logic r, input logic [1:0] a, input logic [7:0] d);
      txn_t t;
      t.m = m; t.rw = r; t.a = a; t.d = d;
      exp_q.push_back(t);
   endtask

   // One clock: sample at the falling edge, score bus cycles and done pulses, then
   // let each finished master drop its request just after the rising edge.
   task automatic tick();
      txn_t t;
      @(negedge clk);
      bus_seen  = iocs;
      done_seen = done;
      gnt_seen  = gnt;
      if (iocs) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL %s/bus_unexpected observed=access addr=%b expected=none", step, ioaddr);
         end
         if (exp_q.size() != 0) begin
            t = exp_q[0];
            check("bus_cycle", {19'd0, gnt, iorw, ioaddr, databus}, {19'd0, oh(t.m), t.rw, t.a, t.d});
         end
      end else begin
         check("bus_idle", {21'd0, iorw, ioaddr, databus}, {21'd0, 1'b1, 2'b01, 8'h96});
      end
      if (done !== 2'b00) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL %s/done_unexpected observed=%b expected=00", step, done);
         end
         if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            check("done_owner", done, oh(t.m));
            if (t.rw) check("rdata", rdata, t.d);
         end
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) if (done_seen[m]) req[m] = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (done_seen != 2'b00) got = 1'b1;
      end
      checks++;
      assert (got) else begin
         failures++;
         $error("FAIL %s/%s observed=no done expected=done within %0d cycles", step, tag, budget);
      end
   endtask

   task automatic wait_bus(input string tag, input int budget, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      while (!got && n < budget) begin
         tick();
         n++;
         if (bus_seen) got = 1'b1;
      end
      checks++;
      assert (got) else begin
         failures++;
         $error("FAIL %s/%s observed=no access expected=access within %0d cycles", step, tag, budget);
      end
   endtask

   task automatic stall_window(input string tag);
      logic any;
      any = 1'b0;
      repeat (3) begin
         tick();
         any = any | bus_seen;
      end
      check(tag, any, 1'b0);
   endtask

   initial begin
      int n;
      rst = 1'b0; req = '0; lock = '0; rw = '1; addr = '0; wdata = '0; rda = 1'b0; tbr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step = "reset";
      check("gnt", gnt, 2'b00);
      check("done", done, 2'b00);
      check("rdata", rdata, 8'h00);
      check("bus", {iocs, iorw, ioaddr, databus}, {1'b0, 1'b1, 2'b01, 8'h96});
      rst = 1'b1;

      step = "t1_tx_write";
      issue(0, 1'b0, 2'b00, 8'h41, 1'b0);
      push_exp(0, 1'b0, 2'b00, 8'h41);
      tick(); check("lat_idle", bus_seen, 1'b0);
      tick(); check("lat_bus", bus_seen, 1'b1);
      tick(); check("lat_done", done_seen, 2'b01);
      tick(); check("gnt_clear", gnt_seen, 2'b00);

      step = "t1b_m1_status";
      issue(1, 1'b1, 2'b01, 8'h00, 1'b0);
      push_exp(1, 1'b1, 2'b01, 8'hC3);
      wait_done("m1", 6);

      step = "t2_rr";
      for (int r = 0; r < 3; r++) begin
         issue(0, 1'b1, 2'b01, 8'h3C, 1'b0);
         issue(1, 1'b1, 2'b01, 8'h3C, 1'b0);
         push_exp(0, 1'b1, 2'b01, 8'hC3);
         push_exp(1, 1'b1, 2'b01, 8'hC3);
         wait_done("first", 6);
         wait_done("second", 6);
      end

      step = "t3_lock";
      issue(0, 1'b0, 2'b11, 8'h00, 1'b1);
      issue(1, 1'b1, 2'b01, 8'h00, 1'b0);
      push_exp(0, 1'b0, 2'b11, 8'h00);
      push_exp(0, 1'b0, 2'b10, 8'h8B);
      push_exp(1, 1'b1, 2'b01, 8'hC3);
      wait_done("hi", 6);
      issue(0, 1'b0, 2'b10, 8'h8B, 1'b1);
      tick();
      check("locked_hold", {bus_seen, gnt_seen}, {1'b0, 2'b01});
      wait_bus("lo", 3, n);
      check("back_to_back", n, 1);
      lock[0] = 1'b0;
      wait_done("lo_done", 3);
      wait_done("m1", 6);

      step = "t4_tbr";
      tbr = 1'b0;
      issue(0, 1'b0, 2'b00, 8'h55, 1'b0);
      issue(1, 1'b1, 2'b01, 8'h00, 1'b0);
      push_exp(1, 1'b1, 2'b01, 8'hC3);
      push_exp(0, 1'b0, 2'b00, 8'h55);
      wait_done("m1", 6);
      stall_window("tx_stall");
      tbr = 1'b1;
      wait_bus("m0", 4, n);
      check("m0_latency", n, 2);
      wait_done("m0", 3);

      step = "t5_rx";
      issue(1, 1'b1, 2'b00, 8'h00, 1'b0);
      stall_window("rx_stall");
      rda = 1'b1;
      push_exp(1, 1'b1, 2'b00, 8'h5A);
      wait_bus("m1", 4, n);
      check("m1_latency", n, 2);
      wait_done("m1", 3);
      issue(0, 1'b0, 2'b11, 8'h01, 1'b0);
      push_exp(0, 1'b0, 2'b11, 8'h01);
      wait_done("wr_after", 6);
      check("rdata_hold", rdata, 8'h5A);

      step = "t6_async_rst";
      issue(0, 1'b0, 2'b10, 8'h77, 1'b0);
      tick();
      #2;
      check("pre_access", {iocs, databus}, {1'b1, 8'h77});
      rst = 1'b0;
      #1;
      check("gnt", gnt, 2'b00);
      check("done", done, 2'b00);
      check("bus", {iocs, iorw, ioaddr, databus}, {1'b0, 1'b1, 2'b01, 8'h96});
      check("rdata", rdata, 8'h00);
      req[0] = 1'b0;
      #1;
      rst = 1'b1;
      repeat (2) tick();

      step = "t7_lock_idle";
      issue(0, 1'b0, 2'b10, 8'h12, 1'b1);
      push_exp(0, 1'b0, 2'b10, 8'h12);
      wait_done("owner", 6);
`ifdef SPART_ARB_LOCK_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         tick();
         check("held", gnt_seen, 2'b01);
      end
      tick();
      check("timeout_release", gnt_seen, 2'b00);
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         check("held", gnt_seen, 2'b01);
      end
`endif
      lock[0] = 1'b0;
      issue(0, 1'b1, 2'b01, 8'h00, 1'b0);
      issue(1, 1'b1, 2'b01, 8'h00, 1'b0);
      push_exp(1, 1'b1, 2'b01, 8'hC3);
      push_exp(0, 1'b1, 2'b01, 8'hC3);
      wait_done("after_m1", 8);
      wait_done("after_m0", 8);

      step = "end";
      check("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=bench completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
